// File: rtl/adder_nbit_seq.sv
// Multi-cycle N-bit adder/subtractor. It resolves one BITS_PER_CYCLE-wide ripple chunk per clock,
// starting with the LSB chunk, and holds the carry between chunks in a flop.

module adder_nbit_seq_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module adder_nbit_seq #(
    parameter int NUM_BITS       = 16,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                sub,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int K   = NUM_BITS / BPC;
    localparam int CW  = (K > 1) ? $clog2(K) : 1;

    generate
        if (NUM_BITS < 2 || BPC < 1 || (NUM_BITS % BPC) != 0) begin : g_bad_param
            $error("adder_nbit_seq: BITS_PER_CYCLE must evenly divide NUM_BITS (>= 2)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] op_a, op_b, work, work_nxt;
    logic                carry;
    logic [CW-1:0]       cnt;
    logic                last, accept;
    int                  lsb;

    logic [BPC-1:0]      ch_a, ch_b, ch_s;
    logic [BPC:0]        ch_c;

    // op_b already holds ~b for subtract, and carry was seeded with 1, so the chunk always adds.
    assign lsb     = int'(cnt) * BPC;
    assign ch_a    = op_a[lsb +: BPC];
    assign ch_b    = op_b[lsb +: BPC];
    assign ch_c[0] = carry;
    assign last    = (cnt == CW'(K - 1));

    adder_nbit_seq_fa u_fa [BPC-1:0] (
        .x  (ch_a),
        .y  (ch_b),
        .ci (ch_c[BPC-1:0]),
        .s  (ch_s),
        .co (ch_c[BPC:1])
    );

    always_comb begin
        work_nxt             = work;
        work_nxt[lsb +: BPC] = ch_s;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? ADD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {NUM_BITS{sub}};
            carry <= sub;
            cnt   <= '0;
        end else if (state == ADD) begin
            work  <= work_nxt;
            carry <= ch_c[BPC];
            cnt   <= cnt + 1'b1;
            // Outputs are held from the previous result until the final chunk lands.
            if (last) begin
                sum       <= work_nxt;
                carry_out <= ch_c[BPC];
                overflow  <= ch_c[BPC] ^ ch_c[BPC-1];
            end
        end
    end
endmodule
